// File: rtl/xge_pkt_tx_gen_if.sv
// Client-side transmit bus between a frame source and the xge_mac pkt_tx_* port.
// The source drives frame words; the MAC returns its almost-full back-pressure flag.
interface xge_pkt_tx_gen_if;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val;
  logic        pkt_tx_sop;
  logic        pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic        pkt_tx_full;

  modport master (
    output pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
    input  pkt_tx_full
  );

  modport slave (
    input  pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
    output pkt_tx_full
  );
endinterface

// File: rtl/xge_pkt_tx_gen.sv
// Burst frame generator for the xge_mac transmit client port: incrementing-byte
// frames of a clamped length, honouring almost-full back-pressure and an idle gap.
module xge_pkt_tx_gen #(
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 9600,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk_156m25,
  input  logic                 reset_156m25,
  input  logic                 start,
  input  logic [15:0]          cfg_pkt_count,
  input  logic [13:0]          cfg_pkt_len,
  xge_pkt_tx_gen_if.master     tx,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          sent_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state, state_nxt;
  logic [15:0] frames_left, frames_left_nxt;
  logic [7:0]  frame_idx, frame_idx_nxt;
  logic [10:0] word_idx, word_idx_nxt;
  logic [10:0] words_m1, words_m1_nxt;
  logic [2:0]  eop_mod, eop_mod_nxt;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  logic        inc_p1, inc_p0;
  logic        full_p1;
  logic        busy_nxt, done_nxt;
  logic [15:0] sent_nxt;

  logic [63:0] data_p0, data_p1;
  logic        vld_p0, vld_p1;
  logic        sop_p0, sop_p1;
  logic        eop_p0, eop_p1;
  logic [2:0]  mod_p0, mod_p1;

  logic [13:0] len_c;
  logic [10:0] words_c;
  logic        last_word;
  logic [63:0] word_c;

  function automatic logic [13:0] clamp_len(input logic [13:0] len);
    logic [13:0] r;
    r = len;
    if (len < 14'(MIN_LEN))
      r = 14'(MIN_LEN);
    else if (len > 14'(MAX_LEN))
      r = 14'(MAX_LEN);
    return r;
  endfunction

  // Byte k of frame f is (f + k) mod 256; bytes past the frame end are zeroed.
  function automatic logic [63:0] build_word(input logic [7:0] f8, input logic [4:0] w_lo,
                                             input logic last, input logic [2:0] m);
    logic [7:0]  base;
    logic [63:0] word;
    base = f8 + {w_lo, 3'b000};
    word = '0;
    for (int j = 0; j < 8; j++) begin
      if (!last || (m == 3'd0) || (j < int'(m)))
        word[63-8*j -: 8] = base + 8'(j);
    end
    return word;
  endfunction

  assign len_c     = clamp_len(cfg_pkt_len);
  assign words_c   = 11'((15'(len_c) + 15'd7) >> 3);
  assign last_word = (word_idx == words_m1);
  assign word_c    = build_word(frame_idx, word_idx[4:0], last_word, eop_mod);

  always_comb begin
    state_nxt       = state;
    frames_left_nxt = frames_left;
    frame_idx_nxt   = frame_idx;
    word_idx_nxt    = word_idx;
    words_m1_nxt    = words_m1;
    eop_mod_nxt     = eop_mod;
    gap_cnt_nxt     = gap_cnt;
    inc_p0          = 1'b0;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    sent_nxt        = inc_p1 ? sent_count + 16'd1 : sent_count;
    data_p0         = '0;
    vld_p0          = 1'b0;
    sop_p0          = 1'b0;
    eop_p0          = 1'b0;
    mod_p0          = 3'd0;

    case (state)
      IDLE: begin
        if (start) begin
          sent_nxt = '0;
          if (cfg_pkt_count == 16'd0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt       = SEND;
            busy_nxt        = 1'b1;
            frames_left_nxt = cfg_pkt_count;
            frame_idx_nxt   = '0;
            word_idx_nxt    = '0;
            words_m1_nxt    = words_c - 11'd1;
            eop_mod_nxt     = len_c[2:0];
          end
        end
      end
      SEND: begin
        // Registered full gives the MAC one word of slack after it asserts.
        if (!full_p1) begin
          vld_p0  = 1'b1;
          sop_p0  = (word_idx == 11'd0);
          data_p0 = word_c;
          if (last_word) begin
            eop_p0          = 1'b1;
            mod_p0          = eop_mod;
            inc_p0          = 1'b1;
            frames_left_nxt = frames_left - 16'd1;
            frame_idx_nxt   = frame_idx + 8'd1;
            word_idx_nxt    = '0;
            gap_cnt_nxt     = '0;
            if ((GAP_CYCLES == 0) && (frames_left != 16'd1))
              state_nxt = SEND;
            else
              state_nxt = GAP;
          end else begin
            word_idx_nxt = word_idx + 11'd1;
          end
        end
      end
      GAP: begin
        // The final gap runs one cycle longer so done lands where the next SOP would.
        gap_cnt_nxt = gap_cnt + 16'd1;
        if ((frames_left != 16'd0) && (gap_cnt + 16'd1 == 16'(GAP_CYCLES))) begin
          state_nxt = SEND;
        end else if ((frames_left == 16'd0) && (gap_cnt == 16'(GAP_CYCLES))) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      state       <= IDLE;
      frames_left <= '0;
      frame_idx   <= '0;
      word_idx    <= '0;
      words_m1    <= '0;
      eop_mod     <= '0;
      gap_cnt     <= '0;
      inc_p1      <= 1'b0;
      full_p1     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sent_count  <= '0;
      data_p1     <= '0;
      vld_p1      <= 1'b0;
      sop_p1      <= 1'b0;
      eop_p1      <= 1'b0;
      mod_p1      <= '0;
    end else begin
      state       <= state_nxt;
      frames_left <= frames_left_nxt;
      frame_idx   <= frame_idx_nxt;
      word_idx    <= word_idx_nxt;
      words_m1    <= words_m1_nxt;
      eop_mod     <= eop_mod_nxt;
      gap_cnt     <= gap_cnt_nxt;
      inc_p1      <= inc_p0;
      full_p1     <= tx.pkt_tx_full;
      busy        <= busy_nxt;
      done        <= done_nxt;
      sent_count  <= sent_nxt;
      data_p1     <= data_p0;
      vld_p1      <= vld_p0;
      sop_p1      <= sop_p0;
      eop_p1      <= eop_p0;
      mod_p1      <= mod_p0;
    end
  end

  // ---- output stage p1 ----
  assign tx.pkt_tx_data = data_p1;
  assign tx.pkt_tx_val  = vld_p1;
  assign tx.pkt_tx_sop  = sop_p1;
  assign tx.pkt_tx_eop  = eop_p1;
  assign tx.pkt_tx_mod  = mod_p1;

endmodule

// File: tb/tb_xge_pkt_tx_gen.sv
// Directed and randomized bursts against a byte-stream reference model of the
// expected frames, timing and back-pressure behaviour of xge_pkt_tx_gen.
module tb_xge_pkt_tx_gen;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 9600;
  localparam int GAP     = 2;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_pkt_count = '0;
  logic [13:0] cfg_pkt_len = '0;
  logic        busy, done;
  logic [15:0] sent_count;

  int errors = 0;
  int checks = 0;

  xge_pkt_tx_gen_if tx();

  xge_pkt_tx_gen #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
    .clk_156m25    (clk),
    .reset_156m25  (rst),
    .start         (start),
    .cfg_pkt_count (cfg_pkt_count),
    .cfg_pkt_len   (cfg_pkt_len),
    .tx            (tx.master),
    .busy          (busy),
    .done          (done),
    .sent_count    (sent_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: full held low; 1: random full; 2: full high before edges 5..7.
  task automatic run_burst(input int cnt, input int len, input int mode, input int restart_at);
    word_t expq[$];
    word_t e;
    int    L, W, cyc, done_cyc, first_val, last_eop, budget;
    bit    got_done, f_prev, full_now;
    logic [63:0] d;

    L = (len < MIN_LEN) ? MIN_LEN : (len > MAX_LEN) ? MAX_LEN : len;
    W = (L + 7) / 8;
    for (int f = 0; f < cnt; f++) begin
      for (int w = 0; w < W; w++) begin
        d = '0;
        for (int j = 0; j < 8; j++) begin
          int k;
          k = 8 * w + j;
          d = {d[55:0], (k < L) ? 8'((f + k) % 256) : 8'h00};
        end
        e.data = d;
        e.sop  = (w == 0);
        e.eop  = (w == W - 1);
        e.mod  = (w == W - 1) ? 3'(L % 8) : 3'd0;
        expq.push_back(e);
      end
    end

    @(negedge clk);
    start = 1'b1;
    cfg_pkt_count = 16'(cnt);
    cfg_pkt_len   = 14'(len);
    tx.pkt_tx_full = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    chk("busy_after_start", busy, (cnt != 0));
    got_done  = done;
    done_cyc  = 0;
    first_val = -1;
    last_eop  = -1;
    f_prev    = 1'b0;
    budget    = cnt * (W + GAP) * 4 + 50;

    while (!got_done && cyc < budget) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc + 1 == restart_at) begin
        start = 1'b1;
        cfg_pkt_count = 16'(cnt + 3);
        cfg_pkt_len   = 14'd200;
      end
      case (mode)
        1:       full_now = ($urandom_range(0, 3) == 0);
        2:       full_now = (cyc + 1 >= 5) && (cyc + 1 <= 7);
        default: full_now = 1'b0;
      endcase
      tx.pkt_tx_full = full_now;
      @(posedge clk); #1;
      cyc++;
      if (f_prev) chk("stall_val", tx.pkt_tx_val, 1'b0);
      f_prev = full_now;
      if (tx.pkt_tx_val) begin
        if (first_val < 0) first_val = cyc;
        if (expq.size() == 0) begin
          chk("extra_word", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          chk("data", tx.pkt_tx_data, e.data);
          chk("sop", tx.pkt_tx_sop, e.sop);
          chk("eop", tx.pkt_tx_eop, e.eop);
          chk("mod", tx.pkt_tx_mod, e.mod);
        end
        if (tx.pkt_tx_sop && last_eop >= 0 && mode == 0)
          chk("gap_len", cyc - last_eop - 1, GAP);
        if (tx.pkt_tx_eop) last_eop = cyc;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    tx.pkt_tx_full = 1'b0;

    chk("done_seen", got_done, 1'b1);
    chk("words_left", expq.size(), 0);
    chk("sent_count", sent_count, 16'(cnt));
    chk("busy_at_done", busy, 1'b0);
    if (mode == 0) begin
      chk("done_latency", done_cyc, (cnt == 0) ? 0 : cnt * (W + GAP) + 1);
      if (cnt > 0) chk("first_sop_latency", first_val, 1);
    end
    @(posedge clk); #1;
    chk("done_pulse_width", done, 1'b0);
    chk("idle_val", tx.pkt_tx_val, 1'b0);
  endtask

  initial begin
    int nval;
    bit reached;
    tx.pkt_tx_full = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", tx.pkt_tx_val, 1'b0);
    chk("rst_data", tx.pkt_tx_data, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sent", sent_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single 64-byte frame
    run_burst(1, 64, 0, -1);
    // Odd length, then clamp-up of a short request
    run_burst(2, 70, 0, -1);
    run_burst(2, 10, 0, -1);
    // Back-pressure mid-frame
    run_burst(1, 128, 2, -1);
    // Burst of three with gaps, and a start pulse while busy
    run_burst(3, 64, 0, -1);
    run_burst(2, 64, 0, 10);
    // Zero-count burst
    run_burst(0, 64, 0, -1);
    // Clamp-down of an oversized request
    run_burst(1, 16383, 0, -1);
    // Randomized bursts with random back-pressure
    for (int i = 0; i < 5; i++)
      run_burst(int'($urandom_range(1, 3)), int'($urandom_range(1, 300)), 1, -1);

    // Reset asserted while word 4 of a frame is on the bus
    @(negedge clk);
    start = 1'b1;
    cfg_pkt_count = 16'd1;
    cfg_pkt_len   = 14'd64;
    @(posedge clk); #1;
    start = 1'b0;
    nval = 0;
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(posedge clk); #1;
      if (tx.pkt_tx_val) nval++;
      if (nval == 5) reached = 1'b1;
    end
    chk("reset_wait_word4", reached, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_val", tx.pkt_tx_val, 1'b0);
    chk("async_rst_data", tx.pkt_tx_data, 64'h0);
    chk("async_rst_sop", tx.pkt_tx_sop, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_sent", sent_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    run_burst(1, 64, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
